// File: rtl/muller_c_pipe.sv
// rtl/muller_c_pipe.sv - clocked Muller C-element micropipeline with four-phase handshakes
//
// Purpose : DEPTH-stage C-element pipeline moving WIDTH-bit tokens between a
//           four-phase upstream (in_req/in_ack) and a four-phase downstream
//           (out_req/out_ack), with a sticky handshake-violation detector.
// Ports   : clk         - single clock, all state on rising edge
//           rst_n       - synchronous active-low reset
//           in_req      - upstream request
//           in_ack      - upstream acknowledge (= c[0])
//           in_data     - upstream token data
//           out_req     - downstream request (= c[DEPTH-1])
//           out_ack     - downstream acknowledge
//           out_data    - downstream token data (= data[DEPTH-1])
//           proto_err   - sticky protocol violation flag
//           stage_state - C-element state vector (only with MULLER_C_STATE_OUT_EN)
// Macro   : MULLER_C_STATE_OUT_EN adds the stage_state port.
module muller_c_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_req,
    output logic             in_ack,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_req,
    input  logic             out_ack,
    output logic [WIDTH-1:0] out_data,
    output logic             proto_err
`ifdef MULLER_C_STATE_OUT_EN
    ,
    output logic [DEPTH-1:0] stage_state
`endif
);

    logic [DEPTH-1:0]            c_q, c_d;
    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic                        err_q, err_d;
    logic                        req_prev_q, req_prev_d;
    logic                        ack_prev_q, ack_prev_d;
    logic                        arm_q, arm_d;

    logic [DEPTH-1:0] a_vec;
    logic [DEPTH-1:0] b_vec;
    logic [DEPTH-1:0] c_chg;
    logic             req_pending;
    logic             ack_idle;

    always_comb begin
        // a: predecessor state (in_req feeds stage 0); b: inverted successor
        // state (~out_ack feeds the last stage). All from current registers.
        a_vec = {c_q[DEPTH-2:0], in_req};
        b_vec = ~{out_ack, c_q[DEPTH-1:1]};

        // C-element as a majority gate: follow a when a==b, else hold.
        c_d   = (a_vec & b_vec) | (c_q & (a_vec | b_vec));
        c_chg = c_d ^ c_q;

        // A stage only flips when its successor already holds its token, so
        // shifting old predecessor data in on a flip never overwrites live data.
        data_d = data_q;
        if (c_chg[0]) begin
            data_d[0] = in_data;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (c_chg[i]) begin
                data_d[i] = data_q[i-1];
            end
        end

        // Request outstanding last cycle (not yet acknowledged) / downstream
        // had nothing to acknowledge last cycle.
        req_pending = req_prev_q ^ c_q[0];
        ack_idle    = ~(ack_prev_q ^ c_q[DEPTH-1]);

        err_d = err_q;
        if (arm_q) begin
            if (((in_req ^ req_prev_q) & req_pending) |
                ((out_ack ^ ack_prev_q) & ack_idle)) begin
                err_d = 1'b1;
            end
        end

        req_prev_d = in_req;
        ack_prev_d = out_ack;
        arm_d      = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q        <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            arm_q      <= 1'b0;
            // Detectors stay disarmed for one edge after reset so the first
            // post-reset sample becomes the reference.
            req_prev_q <= req_prev_d;
            ack_prev_q <= ack_prev_d;
        end else begin
            c_q        <= c_d;
            data_q     <= data_d;
            err_q      <= err_d;
            arm_q      <= arm_d;
            req_prev_q <= req_prev_d;
            ack_prev_q <= ack_prev_d;
        end
    end

    assign in_ack    = c_q[0];
    assign out_req   = c_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign proto_err = err_q;

`ifdef MULLER_C_STATE_OUT_EN
    assign stage_state = c_q;
`endif

endmodule

// File: tb/tb_muller_c_pipe.sv
// tb/tb_muller_c_pipe.sv - directed self-checking bench for muller_c_pipe
module tb_muller_c_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_req;
    logic             in_ack;
    logic [WIDTH-1:0] in_data;
    logic             out_req;
    logic             out_ack;
    logic [WIDTH-1:0] out_data;
    logic             proto_err;
`ifdef MULLER_C_STATE_OUT_EN
    logic [DEPTH-1:0] stage_state;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muller_c_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_req    (in_req),
        .in_ack    (in_ack),
        .in_data   (in_data),
        .out_req   (out_req),
        .out_ack   (out_ack),
        .out_data  (out_data),
        .proto_err (proto_err)
`ifdef MULLER_C_STATE_OUT_EN
        ,
        .stage_state (stage_state)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_ack(input logic v, input string tag);
        int n = 0;
        while (in_ack !== v && n < 50) begin
            tick();
            n++;
        end
        check(tag, {31'd0, in_ack}, {31'd0, v});
    endtask

    task automatic wait_out_req(input logic v, input string tag);
        int n = 0;
        while (out_req !== v && n < 50) begin
            tick();
            n++;
        end
        check(tag, {31'd0, out_req}, {31'd0, v});
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input string tag);
        in_data = d;
        in_req  = 1'b1;
        wait_in_ack(1'b1, {tag, "_ack_hi"});
        in_req  = 1'b0;
        wait_in_ack(1'b0, {tag, "_ack_lo"});
    endtask

    task automatic recv(input logic [WIDTH-1:0] exp, input string tag);
        wait_out_req(1'b1, {tag, "_req_hi"});
        check({tag, "_data"}, {24'd0, out_data}, {24'd0, exp});
        out_ack = 1'b1;
        wait_out_req(1'b0, {tag, "_req_lo"});
        out_ack = 1'b0;
    endtask

    initial begin
        logic seen;

        // Reset with in_req held high
        rst_n   = 1'b0;
        in_req  = 1'b1;
        out_ack = 1'b0;
        in_data = 8'h5A;
        tick();
        tick();
        check("rst_in_ack",   {31'd0, in_ack},    32'd0);
        check("rst_out_req",  {31'd0, out_req},   32'd0);
        check("rst_out_data", {24'd0, out_data},  32'd0);
        check("rst_err",      {31'd0, proto_err}, 32'd0);
`ifdef MULLER_C_STATE_OUT_EN
        check("rst_state", {28'd0, stage_state}, 32'd0);
`endif
        rst_n  = 1'b1;
        in_req = 1'b0;
        tick();
        check("post_rst_in_ack", {31'd0, in_ack}, 32'd0);

        // Single token latency trace
        in_data = 8'hA5;
        in_req  = 1'b1;
        tick();
        check("t0_in_ack",  {31'd0, in_ack},  32'd1);
        check("t0_out_req", {31'd0, out_req}, 32'd0);
`ifdef MULLER_C_STATE_OUT_EN
        check("t0_state", {28'd0, stage_state}, 32'h1);
`endif
        tick();
        check("t1_out_req", {31'd0, out_req}, 32'd0);
`ifdef MULLER_C_STATE_OUT_EN
        check("t1_state", {28'd0, stage_state}, 32'h3);
`endif
        tick();
        check("t2_out_req", {31'd0, out_req}, 32'd0);
`ifdef MULLER_C_STATE_OUT_EN
        check("t2_state", {28'd0, stage_state}, 32'h7);
`endif
        tick();
        check("t3_out_req",  {31'd0, out_req},  32'd1);
        check("t3_out_data", {24'd0, out_data}, 32'hA5);
`ifdef MULLER_C_STATE_OUT_EN
        check("t3_state", {28'd0, stage_state}, 32'hF);
`endif
        in_req = 1'b0;
        wait_in_ack(1'b0, "single_ack_lo");
        out_ack = 1'b1;
        wait_out_req(1'b0, "single_out_lo");
        out_ack = 1'b0;
        tick();
        check("single_err", {31'd0, proto_err}, 32'd0);

        // Stall until full: two tokens fill a four-stage pipe
        send(8'h11, "tok11");
        send(8'h22, "tok22");
        in_data = 8'h33;
        in_req  = 1'b1;
        repeat (6) tick();
        check("full_in_ack", {31'd0, in_ack},    32'd0);
        check("full_err",    {31'd0, proto_err}, 32'd0);

        // Withdraw the unaccepted request: protocol error
        in_req = 1'b0;
        tick();
        check("withdraw_err",    {31'd0, proto_err}, 32'd1);
        check("withdraw_in_ack", {31'd0, in_ack},    32'd0);

        // Pipeline keeps working after the error; order preserved
        recv(8'h11, "drain11");
        recv(8'h22, "drain22");
        repeat (8) tick();
        check("drain_empty", {31'd0, out_req},   32'd0);
        check("err_sticky",  {31'd0, proto_err}, 32'd1);

        rst_n = 1'b0;
        tick();
        check("err_cleared", {31'd0, proto_err}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // Spurious acknowledge while nothing is offered
        out_ack = 1'b1;
        tick();
        check("spurious_ack_err", {31'd0, proto_err}, 32'd1);
        out_ack = 1'b0;
        rst_n   = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("pre_mid_err", {31'd0, proto_err}, 32'd0);

        // Mid-transfer reset with token at stage 2
        in_data = 8'h3C;
        in_req  = 1'b1;
        tick();
        tick();
        tick();
        check("mid_out_req", {31'd0, out_req}, 32'd0);
`ifdef MULLER_C_STATE_OUT_EN
        check("mid_state", {28'd0, stage_state}, 32'h7);
`endif
        rst_n  = 1'b0;
        in_req = 1'b0;
        tick();
        check("mid_rst_in_ack",   {31'd0, in_ack},    32'd0);
        check("mid_rst_out_req",  {31'd0, out_req},   32'd0);
        check("mid_rst_out_data", {24'd0, out_data},  32'd0);
        check("mid_rst_err",      {31'd0, proto_err}, 32'd0);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_data == 8'h3C || out_req) seen = 1'b1;
        end
        check("mid_rst_discard", {31'd0, seen}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
